cacheline_burst_adapter: RTL and testbench



---
 rtl/cache_types.sv | 46 ++++
 rtl/cacheline_burst_adapter.sv | 110 +++++++++++
 tb/tb_cacheline_burst_adapter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared types for the cache line port and the narrower burst memory bus.
// Module parameters of the same names take precedence over these defaults.
package cache_types;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BUS_W    = 64;
    localparam int unsigned BEATS    = LINE_W / BUS_W;
    localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);

    // Cache-side, line-level view
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [LINE_W-1:0] wdata;
    } line_request_t;

    typedef struct packed {
        logic [LINE_W-1:0] rdata;
        logic              resp;
    } line_response_t;

    // Memory-side, beat-level view
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              read;
        logic              write;
        logic [BUS_W-1:0]  w_data;
    } burst_request_t;

    typedef struct packed {
        logic [BUS_W-1:0] r_data;
        logic             rvalid;
        logic             ready;
    } burst_response_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        DONE
    } burst_state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Converts single-handshake cache line reads/writes into LINE_W/BUS_W-beat
// bursts, assembling read beats and serialising write beats in ascending order.
module cacheline_burst_adapter
    import cache_types::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BUS_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [LINE_W-1:0] c_wdata,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_resp,
    output logic [ADDR_W-1:0] b_addr,
    output logic              b_read,
    output logic              b_write,
    output logic [BUS_W-1:0]  b_wdata,
    input  logic              b_ready,
    input  logic [BUS_W-1:0]  b_rdata,
    input  logic              b_rvalid
);

    localparam int unsigned NBEATS = LINE_W / BUS_W;
    localparam int unsigned CNT_W  = $clog2(NBEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    burst_state_t                   state;
    logic [CNT_W-1:0]               cnt;
    logic [NBEATS-1:0][BUS_W-1:0]   wbuf;
    logic [NBEATS-1:0][BUS_W-1:0]   rline;

    assign c_rdata = rline;

    // b_wdata is preloaded one beat ahead so the bus sees a registered value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wbuf    <= '0;
            rline   <= '0;
            b_addr  <= '0;
            b_read  <= 1'b0;
            b_write <= 1'b0;
            b_wdata <= '0;
            c_resp  <= 1'b0;
        end else begin
            c_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_read) begin
                        b_addr <= c_addr & ~OFF_MASK;
                        b_read <= 1'b1;
                        state  <= RD_REQ;
                    end else if (c_write) begin
                        b_addr  <= c_addr & ~OFF_MASK;
                        wbuf    <= c_wdata;
                        b_wdata <= c_wdata[BUS_W-1:0];
                        b_write <= 1'b1;
                        cnt     <= '0;
                        state   <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    if (b_ready) begin
                        b_read <= 1'b0;
                        cnt    <= '0;
                        state  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (b_rvalid) begin
                        rline[cnt] <= b_rdata;
                        cnt        <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            c_resp <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WR_DATA: begin
                    if (b_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            b_write <= 1'b0;
                            b_wdata <= '0;
                            c_resp  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            b_wdata <= wbuf[cnt + 1'b1];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: default 256/64 instance driven from a
// vector table with a response scoreboard, plus a 128/32 instance.
module tb_cacheline_burst_adapter;

    typedef struct {
        bit           rd;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] rline;
        int           stall_beat;
        int           stall_cyc;
        bit           spurious;
        logic [31:0]  exp_addr;
        int           exp_lat;
    } vec_t;

    typedef struct {
        bit           rd;
        logic [255:0] rdata;
        int           lat;
        logic [31:0]  addr;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  c_addr;
    logic         c_read, c_write;
    logic [255:0] c_wdata, c_rdata;
    logic         c_resp;
    logic [31:0]  b_addr;
    logic         b_read, b_write;
    logic [63:0]  b_wdata, b_rdata;
    logic         b_ready, b_rvalid;

    logic [31:0]  s_c_addr;
    logic         s_c_read, s_c_write;
    logic [127:0] s_c_wdata, s_c_rdata;
    logic         s_c_resp;
    logic [31:0]  s_b_addr;
    logic         s_b_read, s_b_write;
    logic [31:0]  s_b_wdata, s_b_rdata;
    logic         s_b_ready, s_b_rvalid;

    int           total = 0;
    int           bad   = 0;
    sb_t          sb[$];
    logic [255:0] last_rd = '0;
    vec_t         vecs[5];
    vec_t         cv, rv, rv2;

    always #5 clk = ~clk;

    cacheline_burst_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .c_addr(c_addr), .c_read(c_read), .c_write(c_write), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_resp(c_resp),
        .b_addr(b_addr), .b_read(b_read), .b_write(b_write), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
    );

    cacheline_burst_adapter #(.ADDR_W(32), .LINE_W(128), .BUS_W(32)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .c_addr(s_c_addr), .c_read(s_c_read), .c_write(s_c_write), .c_wdata(s_c_wdata),
        .c_rdata(s_c_rdata), .c_resp(s_c_resp),
        .b_addr(s_b_addr), .b_read(s_b_read), .b_write(s_b_write), .b_wdata(s_b_wdata),
        .b_ready(s_b_ready), .b_rdata(s_b_rdata), .b_rvalid(s_b_rvalid)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        sb_t e;
        e.rd   = v.rd;
        e.addr = v.exp_addr;
        e.lat  = v.exp_lat;
        if (v.rd) last_rd = v.rline;
        e.rdata = last_rd;
        sb.push_back(e);
        c_addr  = v.addr;
        c_wdata = v.wline;
        if (v.rd) c_read = 1'b1;
        else      c_write = 1'b1;
    endtask

    // Acts as the burst memory; pops the scoreboard on every c_resp.
    // abort_after >= 0 returns just before that read beat would be delivered.
    task automatic serve(input vec_t v, input int n_resp, input int abort_after);
        int  n, got, rbeat, wbeat, stall_left;
        bit  rd_phase;
        sb_t e;
        n = 0; got = 0; rbeat = 0; wbeat = 0; rd_phase = 0;
        stall_left = v.stall_cyc;
        while (got < n_resp) begin
            @(negedge clk);
            n++;
            b_ready  = 1'b0;
            b_rvalid = 1'b0;
            b_rdata  = '0;
            chk("rd_wr_exclusive", {255'b0, b_read & b_write}, '0);
            if (n > 300) begin
                chk("resp_timeout", 256'(n), 256'(0));
                return;
            end
            if (c_resp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 256'(1), 256'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_latency", 256'(n), 256'(e.lat));
                    chk("c_rdata", c_rdata, e.rdata);
                    chk("b_addr", {224'b0, b_addr}, {224'b0, e.addr});
                    if (e.rd) c_read = 1'b0;
                    else      c_write = 1'b0;
                end
                got++;
                n = 0; rbeat = 0; wbeat = 0; rd_phase = 0;
                stall_left = v.stall_cyc;
            end else if (b_read) begin
                b_ready  = 1'b1;
                rd_phase = 1'b1;
                if (v.spurious) begin
                    b_rvalid = 1'b1;
                    b_rdata  = '1;
                end
            end else if (b_write) begin
                chk("b_wdata", {192'b0, b_wdata}, {192'b0, v.wline[wbeat*64 +: 64]});
                if (wbeat == v.stall_beat && stall_left > 0) stall_left--;
                else begin
                    b_ready = 1'b1;
                    wbeat++;
                end
            end else if (rd_phase && rbeat < 4) begin
                if (abort_after >= 0 && rbeat == abort_after) return;
                if (rbeat == v.stall_beat && stall_left > 0) stall_left--;
                else begin
                    b_rvalid = 1'b1;
                    b_rdata  = v.rline[rbeat*64 +: 64];
                    rbeat++;
                end
            end
        end
    endtask

    task automatic run_s(input bit rd, input logic [31:0] addr, input logic [127:0] line,
                         input logic [31:0] exp_addr, input int exp_lat, input logic [127:0] exp_rdata);
        int n, beat;
        bit rdp, done;
        n = 0; beat = 0; rdp = 0; done = 0;
        @(negedge clk);
        s_c_addr  = addr;
        s_c_wdata = line;
        s_c_read  = rd;
        s_c_write = !rd;
        while (!done) begin
            @(negedge clk);
            n++;
            s_b_ready  = 1'b0;
            s_b_rvalid = 1'b0;
            if (n > 100) begin
                chk("s_timeout", 256'(n), 256'(0));
                done = 1;
            end else if (s_c_resp) begin
                chk("s_latency", 256'(n), 256'(exp_lat));
                chk("s_c_rdata", {128'b0, s_c_rdata}, {128'b0, exp_rdata});
                chk("s_b_addr", {224'b0, s_b_addr}, {224'b0, exp_addr});
                s_c_read  = 1'b0;
                s_c_write = 1'b0;
                done = 1;
            end else if (s_b_read) begin
                s_b_ready = 1'b1;
                rdp = 1'b1;
            end else if (s_b_write) begin
                chk("s_b_wdata", {224'b0, s_b_wdata}, {224'b0, line[beat*32 +: 32]});
                s_b_ready = 1'b1;
                beat++;
            end else if (rdp && beat < 4) begin
                s_b_rvalid = 1'b1;
                s_b_rdata  = line[beat*32 +: 32];
                beat++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{rd:1'b1, addr:32'h0000_1234, wline:'0,
                    rline:256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    stall_beat:0, stall_cyc:0, spurious:1'b0, exp_addr:32'h0000_1220, exp_lat:6};
        vecs[1] = '{rd:1'b0, addr:32'hDEAD_BEEF,
                    wline:256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD,
                    rline:'0, stall_beat:1, stall_cyc:2, spurious:1'b0, exp_addr:32'hDEAD_BEE0, exp_lat:7};
        vecs[2] = '{rd:1'b1, addr:32'h0000_003F, wline:'0,
                    rline:256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_A5A5A5A5A5A5A5A5,
                    stall_beat:2, stall_cyc:3, spurious:1'b1, exp_addr:32'h0000_0020, exp_lat:9};
        vecs[3] = '{rd:1'b1, addr:32'hFFFF_FFFF, wline:'0,
                    rline:256'h8000000000000001_7FFFFFFFFFFFFFFE_0000000000000000_FFFFFFFFFFFFFFFF,
                    stall_beat:0, stall_cyc:1, spurious:1'b0, exp_addr:32'hFFFF_FFE0, exp_lat:7};
        vecs[4] = '{rd:1'b0, addr:32'h0000_0040,
                    wline:256'h1000000000000004_2000000000000003_3000000000000002_4000000000000001,
                    rline:'0, stall_beat:3, stall_cyc:1, spurious:1'b0, exp_addr:32'h0000_0040, exp_lat:6};

        rst_n = 1'b0;
        c_addr = '0; c_read = 1'b0; c_write = 1'b0; c_wdata = '0;
        b_ready = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        s_c_addr = '0; s_c_read = 1'b0; s_c_write = 1'b0; s_c_wdata = '0;
        s_b_ready = 1'b0; s_b_rvalid = 1'b0; s_b_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_c_resp",  {255'b0, c_resp}, '0);
        chk("rst_c_rdata", c_rdata, '0);
        chk("rst_b_ctrl",  {254'b0, b_read, b_write}, '0);
        chk("rst_b_addr",  {224'b0, b_addr}, '0);
        chk("rst_b_wdata", {192'b0, b_wdata}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vecs[i].spurious) begin
                b_rvalid = 1'b1;
                b_rdata  = '1;
                @(negedge clk);
                b_rvalid = 1'b0;
                b_rdata  = '0;
            end
            start(vecs[i]);
            serve(vecs[i], 1, -1);
        end

        // Read and write together: read first, then the held write, two pulses only
        cv = '{rd:1'b1, addr:32'h0000_2468,
               wline:256'hCAFE0000CAFE0003_CAFE0000CAFE0002_CAFE0000CAFE0001_CAFE0000CAFE0000,
               rline:256'hBEEF0000BEEF0003_BEEF0000BEEF0002_BEEF0000BEEF0001_BEEF0000BEEF0000,
               stall_beat:0, stall_cyc:0, spurious:1'b0, exp_addr:32'h0000_2460, exp_lat:6};
        @(negedge clk);
        start(cv);
        cv.rd = 1'b0;
        cv.exp_lat = 6;
        start(cv);
        c_read = 1'b1;
        serve(cv, 2, -1);
        @(negedge clk);
        chk("combo_no_third_resp", {255'b0, c_resp}, '0);
        @(negedge clk);
        chk("combo_idle_after", {253'b0, c_resp, b_read, b_write}, '0);

        // Reset mid-read after beats 0..2
        rv = '{rd:1'b1, addr:32'h0000_8000, wline:'0,
               rline:256'h0000000000000D04_0000000000000D03_0000000000000D02_0000000000000D01,
               stall_beat:0, stall_cyc:0, spurious:1'b0, exp_addr:32'h0000_8000, exp_lat:6};
        @(negedge clk);
        c_addr = rv.addr;
        c_read = 1'b1;
        serve(rv, 1, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_c_resp",  {255'b0, c_resp}, '0);
        chk("midrst_c_rdata", c_rdata, '0);
        chk("midrst_b_ctrl",  {254'b0, b_read, b_write}, '0);
        chk("midrst_b_addr",  {224'b0, b_addr}, '0);
        chk("midrst_b_wdata", {192'b0, b_wdata}, '0);
        c_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        rv2 = '{rd:1'b1, addr:32'h0000_9ABC, wline:'0,
                rline:256'h5555000000000004_5555000000000003_5555000000000002_5555000000000001,
                stall_beat:0, stall_cyc:0, spurious:1'b0, exp_addr:32'h0000_9AA0, exp_lat:6};
        @(negedge clk);
        start(rv2);
        serve(rv2, 1, -1);

        // Narrow instance: 4 beats of 32 bits, 16-byte alignment
        run_s(1'b1, 32'h0000_1234, 128'h44444444_33333333_22222222_11111111,
              32'h0000_1230, 6, 128'h44444444_33333333_22222222_11111111);
        run_s(1'b0, 32'h0000_567F, 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D,
              32'h0000_5670, 5, 128'h44444444_33333333_22222222_11111111);

        chk("scoreboard_drained", 256'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
